vc_queue_multichan: RTL and testbench
=====================================

// Module: vc_queue_multichan
// PURPOSE
//  - p_num_chans independent FIFO channels, each p_num_msgs deep, sharing one dequeue port.
//  - Per-channel val/rdy enqueue; round-robin arbiter picks the channel to dequeue.
//  - Dequeue output is held stable while stalled.
//  - Multi-channel successor to the single-stream normal queue; used for virtual-channel buffering at network/memory ports.
// PARAMETERS
//  p_msg_nbits   8   message width in bits
//  p_num_msgs    4   depth per channel (>=2, any integer, not restricted to power of two)
//  p_num_chans   4   number of channels (>=2, any integer)
//  c_chan_nbits  $clog2(p_num_chans)   derived, do not override
//  c_cnt_nbits   $clog2(p_num_msgs+1)  derived, do not override
// PORTS
//  clk        in   1                        clock
//  reset      in   1                        synchronous, active-low reset
//  enq_val    in   p_num_chans              per-channel enqueue valid
//  enq_rdy    out  p_num_chans              per-channel enqueue ready
//  enq_msg    in   p_num_chans*p_msg_nbits  channel i at [i*p_msg_nbits +: p_msg_nbits]
//  deq_val    out  1                        dequeue valid
//  deq_rdy    in   1                        dequeue ready
//  deq_msg    out  p_msg_nbits              head message of granted channel
//  deq_chan   out  c_chan_nbits             granted channel id
//  num_free   out  p_num_chans*c_cnt_nbits  free entries, channel i at [i*c_cnt_nbits +: c_cnt_nbits]
//  flush      in   p_num_chans              per-channel flush (only with VC_QUEUE_MC_FLUSH_EN)
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - enq_ptr, deq_ptr, count, prio and lock all clear to 0.
//    - Following cycle: enq_rdy = all 1, deq_val = 0, deq_chan = 0, num_free[i] = p_num_msgs.
//    - Storage is not reset; deq_msg is don't-care while deq_val = 0.
//    - Reset mid-operation discards all contents; behaviour afterwards is identical to power-up.
//  - Per channel i:
//    - Circular buffer; enq_rdy[i] = (count[i] != p_num_msgs). No pipe behaviour: a full channel never accepts.
//    - Handshakes: do_enq[i] = enq_val[i] & enq_rdy[i] writes enq_msg slice at enq_ptr[i].
//    - Pointers advance p_num_msgs-1 -> 0.
//    - Any subset of channels may enqueue in the same cycle.
//    - No bypass: data enqueued in cycle t is dequeuable no earlier than t+1 (min latency 1).
//    - count next = count + do_enq[i] - (do_deq & grant==i). Simultaneous enq+deq on one channel leaves count unchanged.
//    - num_free[i] = p_num_msgs - count[i] (registered-state derived).
//  - Arbitration:
//    - nonempty[i] = count[i] != 0; deq_val = |nonempty.
//    - rr_grant = first nonempty channel scanning prio, prio+1, ... cyclically.
//    - deq_chan = lock ? lock_chan : rr_grant; deq_msg = head of deq_chan.
//    - do_deq = deq_val & deq_rdy; on do_deq, deq_ptr[deq_chan] advances and prio <= deq_chan+1, wrapping p_num_chans-1 -> 0.
//  - Stall lock:
//    - deq_val & ~deq_rdy sets lock = 1, lock_chan = deq_chan. Cleared on do_deq.
//    - deq_chan/deq_msg are stable while stalled even if higher-priority channels fill.
//    - deq_val/deq_chan/deq_msg never depend combinationally on deq_rdy or enq_*.
// CONFIGURATION
//  - `VC_QUEUE_MC_FLUSH_EN defined:
//    - flush port exists. flush[i] = 1 sets count, enq_ptr, deq_ptr of channel i to 0 next cycle.
//    - Same-cycle enq to i is dropped (flush wins; enq_rdy[i] still reflects pre-flush state).
//    - Same-cycle deq from i completes normally; the consumer keeps the message.
//    - If lock_chan == i, lock clears; the only case deq_val may fall while stalled.
//  - Undefined: no flush port, no flush logic.
// TESTING
//  1. reset=0 for 2 cycles, then 1 -> enq_rdy=4'b1111, deq_val=0, each num_free=4.
//  2. enq ch2 0xA0..0xA3, deq_rdy=0 -> enq_rdy[2]=0 after 4th, num_free[2]=0, others 4; then deq_rdy=1 -> A0,A1,A2,A3, deq_chan=2.
//  3. ch0,1,3 hold 2 msgs each, deq_rdy=1 -> deq_chan 0,1,3,0,1,3; then deq_val=0.
//  4. prio=1, only ch3 nonempty, deq_rdy=0; enq ch1 -> deq_chan stays 3, msg stable; deq_rdy=1 -> ch3 then ch1.
//  5. ch0 steady enq+deq each cycle for 10 msgs 0x00..0x09 -> in order across pointer wrap, count constant; reset=0 mid-stream -> all num_free=4, deq_val=0.
//  6. FLUSH_EN: ch2 holds 3 msgs, locked on ch2, flush[2]=1 with enq_val[2]=1 -> next cycle num_free[2]=4, enq dropped, lock cleared, arb moves on.

Source files
------------

// File: rtl/vc_queue_multichan_if.sv
// rtl/vc_queue_multichan_if.sv - enqueue/dequeue bundle for vc_queue_multichan
// The flush vector and its modport entries exist only when VC_QUEUE_MC_FLUSH_EN is defined.
interface vc_queue_multichan_if #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_msgs  = 4,
    parameter int p_num_chans = 4
);
    localparam int c_chan_nbits = $clog2(p_num_chans);
    localparam int c_cnt_nbits  = $clog2(p_num_msgs + 1);

    logic [p_num_chans-1:0]             enq_val;
    logic [p_num_chans-1:0]             enq_rdy;
    logic [p_num_chans*p_msg_nbits-1:0] enq_msg;
    logic                               deq_val;
    logic                               deq_rdy;
    logic [p_msg_nbits-1:0]             deq_msg;
    logic [c_chan_nbits-1:0]            deq_chan;
    logic [p_num_chans*c_cnt_nbits-1:0] num_free;
`ifdef VC_QUEUE_MC_FLUSH_EN
    logic [p_num_chans-1:0]             flush;

    modport master (
        output enq_val, enq_msg, deq_rdy, flush,
        input  enq_rdy, deq_val, deq_msg, deq_chan, num_free
    );
    modport slave (
        input  enq_val, enq_msg, deq_rdy, flush,
        output enq_rdy, deq_val, deq_msg, deq_chan, num_free
    );
`else
    modport master (
        output enq_val, enq_msg, deq_rdy,
        input  enq_rdy, deq_val, deq_msg, deq_chan, num_free
    );
    modport slave (
        input  enq_val, enq_msg, deq_rdy,
        output enq_rdy, deq_val, deq_msg, deq_chan, num_free
    );
`endif
endinterface

// File: rtl/vc_queue_multichan.sv
// rtl/vc_queue_multichan.sv - multi-channel FIFO with round-robin shared dequeue port
// Per-channel flush is compiled in only when VC_QUEUE_MC_FLUSH_EN is defined.
module vc_queue_multichan #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_msgs  = 4,
    parameter int p_num_chans = 4
) (
    input  logic              clk,
    input  logic              reset,
    vc_queue_multichan_if.slave q
);
    localparam int c_chan_nbits = $clog2(p_num_chans);
    localparam int c_cnt_nbits  = $clog2(p_num_msgs + 1);
    localparam int c_ptr_nbits  = $clog2(p_num_msgs);

    localparam logic [c_cnt_nbits-1:0]  c_full     = c_cnt_nbits'(p_num_msgs);
    localparam logic [c_ptr_nbits-1:0]  c_ptr_last = c_ptr_nbits'(p_num_msgs - 1);
    localparam logic [c_chan_nbits-1:0] c_chan_last = c_chan_nbits'(p_num_chans - 1);

    typedef enum logic {ST_OPEN, ST_HELD} lock_state_t;

    logic [p_msg_nbits-1:0]  mem     [p_num_chans][p_num_msgs];
    logic [c_cnt_nbits-1:0]  count   [p_num_chans];
    logic [c_ptr_nbits-1:0]  enq_ptr [p_num_chans];
    logic [c_ptr_nbits-1:0]  deq_ptr [p_num_chans];

    logic [p_num_chans-1:0]  enq_rdy;
    logic [p_num_chans-1:0]  nonempty;
    logic [p_num_chans-1:0]  do_enq;
    logic [p_num_chans-1:0]  deq_hit;
    logic [p_num_chans-1:0]  flush_v;

    logic [c_chan_nbits-1:0] prio;
    logic [c_chan_nbits-1:0] lock_chan;
    logic [c_chan_nbits-1:0] rr_grant;
    logic [c_chan_nbits-1:0] deq_chan;
    logic                    deq_val;
    logic                    do_deq;
    lock_state_t             state_q;
    lock_state_t             state_d;

`ifdef VC_QUEUE_MC_FLUSH_EN
    assign flush_v = q.flush;
`else
    assign flush_v = '0;
`endif

    function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // A flushed channel drops its same-cycle enqueue even though enq_rdy was high.
    always_comb begin
        nonempty = '0;
        enq_rdy  = '0;
        do_enq   = '0;
        deq_hit  = '0;
        for (int i = 0; i < p_num_chans; i++) begin
            nonempty[i] = (count[i] != '0);
            enq_rdy[i]  = (count[i] != c_full);
            do_enq[i]   = q.enq_val[i] & enq_rdy[i] & ~flush_v[i];
            deq_hit[i]  = do_deq && (deq_chan == c_chan_nbits'(i));
        end
    end

    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < p_num_chans; k++) begin
            idx = int'(prio) + k;
            if (idx >= p_num_chans) idx = idx - p_num_chans;
            if (!found && nonempty[idx]) begin
                rr_grant = c_chan_nbits'(idx);
                found    = 1'b1;
            end
        end
    end

    assign deq_val  = |nonempty;
    assign deq_chan = (state_q == ST_HELD) ? lock_chan : rr_grant;
    assign do_deq   = deq_val & q.deq_rdy;

    // The grant is frozen once the consumer stalls, so later arrivals cannot reorder it.
    always_comb begin
        state_d = state_q;
        if (do_deq) begin
            state_d = ST_OPEN;
        end else if (deq_val) begin
            state_d = ST_HELD;
        end
        if (flush_v[deq_chan]) begin
            state_d = ST_OPEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_OPEN;
            lock_chan <= '0;
            prio      <= '0;
        end else begin
            state_q <= state_d;
            if (deq_val && !q.deq_rdy) begin
                lock_chan <= deq_chan;
            end
            if (do_deq) begin
                prio <= (deq_chan == c_chan_last) ? '0 : deq_chan + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_chans; i++) begin
            if (!reset || flush_v[i]) begin
                count[i]   <= '0;
                enq_ptr[i] <= '0;
                deq_ptr[i] <= '0;
            end else begin
                if (do_enq[i]) enq_ptr[i] <= ptr_inc(enq_ptr[i]);
                if (deq_hit[i]) deq_ptr[i] <= ptr_inc(deq_ptr[i]);
                count[i] <= count[i] + c_cnt_nbits'(do_enq[i]) - c_cnt_nbits'(deq_hit[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_chans; i++) begin
            if (do_enq[i]) begin
                mem[i][enq_ptr[i]] <= q.enq_msg[i*p_msg_nbits +: p_msg_nbits];
            end
        end
    end

    always_comb begin
        q.num_free = '0;
        for (int i = 0; i < p_num_chans; i++) begin
            q.num_free[i*c_cnt_nbits +: c_cnt_nbits] = c_full - count[i];
        end
    end

    assign q.enq_rdy  = enq_rdy;
    assign q.deq_val  = deq_val;
    assign q.deq_chan = deq_chan;
    assign q.deq_msg  = mem[deq_chan][deq_ptr[deq_chan]];
endmodule

// File: tb/tb_vc_queue_multichan.sv
// tb/tb_vc_queue_multichan.sv - table-driven bench for vc_queue_multichan
// Rows give this cycle's inputs and the outputs expected before the next edge.
module tb_vc_queue_multichan;
    localparam int NM = 4;
    localparam int NC = 4;
    localparam int MB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_queue_multichan_if #(.p_msg_nbits(MB), .p_num_msgs(NM), .p_num_chans(NC)) q ();

    vc_queue_multichan #(.p_msg_nbits(MB), .p_num_msgs(NM), .p_num_chans(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    typedef struct {
        logic [3:0]  ev;
        logic [31:0] em;
        logic        dr;
        logic        rst;
        logic [3:0]  fl;
        logic        chk;
        logic        cc;
        logic [3:0]  erdy;
        logic        edv;
        logic [1:0]  ech;
        logic [7:0]  emsg;
        logic [11:0] enf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [11:0] nf(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [31:0] m4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(input logic [3:0] ev, input logic [31:0] em, input logic dr,
                                input logic rst, input logic chk, input logic cc,
                                input logic [3:0] erdy, input logic edv, input logic [1:0] ech,
                                input logic [7:0] emsg, input logic [11:0] enf,
                                input logic [3:0] fl);
        vec_t v;
        v.ev = ev; v.em = em; v.dr = dr; v.rst = rst; v.fl = fl;
        v.chk = chk; v.cc = cc; v.erdy = erdy; v.edv = edv; v.ech = ech;
        v.emsg = emsg; v.enf = enf;
        return v;
    endfunction

    task automatic add(input logic [3:0] ev, input logic [31:0] em, input logic dr,
                       input logic rst, input logic chk, input logic cc,
                       input logic [3:0] erdy, input logic edv, input logic [1:0] ech,
                       input logic [7:0] emsg, input logic [11:0] enf);
        vecs.push_back(mk(ev, em, dr, rst, chk, cc, erdy, edv, ech, emsg, enf, 4'b0000));
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        q.enq_val = v.ev;
        q.enq_msg = v.em;
        q.deq_rdy = v.dr;
        reset     = v.rst;
`ifdef VC_QUEUE_MC_FLUSH_EN
        q.flush   = v.fl;
`endif
        if (v.chk) begin
            cmp({tag, " enq_rdy"},  32'(q.enq_rdy),  32'(v.erdy));
            cmp({tag, " deq_val"},  32'(q.deq_val),  32'(v.edv));
            cmp({tag, " num_free"}, 32'(q.num_free), 32'(v.enf));
            if (v.edv || v.cc) cmp({tag, " deq_chan"}, 32'(q.deq_chan), 32'(v.ech));
            if (v.edv)         cmp({tag, " deq_msg"},  32'(q.deq_msg),  32'(v.emsg));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] all4;
        all4 = nf(4, 4, 4, 4);

        // reset state
        add(4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, all4);
        add(4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, all4);
        add(4'b0000, 0, 0, 1, 1, 1, 4'hF, 0, 0, 0, all4);

        // fill ch2 while stalled, refuse when full, then drain in order
        add(4'b0100, m4(0, 0, 'hA0, 0), 0, 1, 1, 0, 4'hF,    0, 0, 0,     all4);
        add(4'b0100, m4(0, 0, 'hA1, 0), 0, 1, 1, 0, 4'hF,    1, 2, 'hA0, nf(4, 4, 3, 4));
        add(4'b0100, m4(0, 0, 'hA2, 0), 0, 1, 1, 0, 4'hF,    1, 2, 'hA0, nf(4, 4, 2, 4));
        add(4'b0100, m4(0, 0, 'hA3, 0), 0, 1, 1, 0, 4'hF,    1, 2, 'hA0, nf(4, 4, 1, 4));
        add(4'b0100, m4(0, 0, 'hA4, 0), 0, 1, 1, 0, 4'b1011, 1, 2, 'hA0, nf(4, 4, 0, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'b1011, 1, 2, 'hA0, nf(4, 4, 0, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF,    1, 2, 'hA1, nf(4, 4, 1, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF,    1, 2, 'hA2, nf(4, 4, 2, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF,    1, 2, 'hA3, nf(4, 4, 3, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF,    0, 0, 0,     all4);

        // mid-run reset, then round-robin over ch0,1,3
        add(4'b0000, 0,                     0, 0, 1, 0, 4'hF, 0, 0, 0,    all4);
        add(4'b1011, m4('h10, 'h20, 0, 'h30), 0, 1, 1, 1, 4'hF, 0, 0, 0,    all4);
        add(4'b1011, m4('h11, 'h21, 0, 'h31), 0, 1, 1, 0, 4'hF, 1, 0, 'h10, nf(3, 3, 4, 3));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 0, 'h10, nf(2, 2, 4, 2));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 1, 'h20, nf(3, 2, 4, 2));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 3, 'h30, nf(3, 3, 4, 2));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 0, 'h11, nf(3, 3, 4, 3));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 1, 'h21, nf(4, 3, 4, 3));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 1, 3, 'h31, nf(4, 4, 4, 3));
        add(4'b0000, 0,                     1, 1, 1, 0, 4'hF, 0, 0, 0,    all4);

        // prio moves to 1, lock on ch3 holds while ch1 fills
        add(4'b0001, m4('h40, 0, 0, 0), 1, 1, 1, 0, 4'hF, 0, 0, 0,    all4);
        add(4'b1000, m4(0, 0, 0, 'h43), 1, 1, 1, 0, 4'hF, 1, 0, 'h40, nf(3, 4, 4, 4));
        add(4'b0010, m4(0, 'h41, 0, 0), 0, 1, 1, 0, 4'hF, 1, 3, 'h43, nf(4, 4, 4, 3));
        add(4'b0000, 0,                 0, 1, 1, 0, 4'hF, 1, 3, 'h43, nf(4, 3, 4, 3));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF, 1, 3, 'h43, nf(4, 3, 4, 3));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF, 1, 1, 'h41, nf(4, 3, 4, 4));
        add(4'b0000, 0,                 1, 1, 1, 0, 4'hF, 0, 0, 0,    all4);

        // streaming through ch0 across pointer wrap, then reset mid-stream
        add(4'b0001, m4(0, 0, 0, 0), 1, 1, 1, 0, 4'hF, 0, 0, 0, all4);
        for (int k = 1; k < 10; k++)
            add(4'b0001, m4(k, 0, 0, 0), 1, 1, 1, 0, 4'hF, 1, 0, 8'(k - 1), nf(3, 4, 4, 4));
        add(4'b0001, m4('h0A, 0, 0, 0), 1, 0, 1, 0, 4'hF, 1, 0, 'h09, nf(3, 4, 4, 4));
        add(4'b0000, 0,                 0, 1, 1, 1, 4'hF, 0, 0, 0,    all4);
        add(4'b0000, 0,                 1, 1, 1, 1, 4'hF, 0, 0, 0,    all4);

        q.enq_val = '0;
        q.enq_msg = '0;
        q.deq_rdy = 1'b0;
`ifdef VC_QUEUE_MC_FLUSH_EN
        q.flush   = '0;
`endif
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));

`ifdef VC_QUEUE_MC_FLUSH_EN
        // flush the locked channel while it also tries to enqueue
        apply(mk(4'b1100, m4(0, 0, 'h60, 'h70), 0, 1, 1, 0, 4'hF, 0, 0, 0,    all4,           4'b0000), "fl0");
        apply(mk(4'b0100, m4(0, 0, 'h61, 0),    0, 1, 1, 0, 4'hF, 1, 2, 'h60, nf(4, 4, 3, 3), 4'b0000), "fl1");
        apply(mk(4'b0100, m4(0, 0, 'h62, 0),    0, 1, 1, 0, 4'hF, 1, 2, 'h60, nf(4, 4, 2, 3), 4'b0000), "fl2");
        apply(mk(4'b0100, m4(0, 0, 'h63, 0),    0, 1, 1, 0, 4'hF, 1, 2, 'h60, nf(4, 4, 1, 3), 4'b0100), "fl3");
        apply(mk(4'b0000, 0,                    0, 1, 1, 0, 4'hF, 1, 3, 'h70, nf(4, 4, 4, 3), 4'b0000), "fl4");
        apply(mk(4'b0000, 0,                    1, 1, 1, 0, 4'hF, 1, 3, 'h70, nf(4, 4, 4, 3), 4'b0000), "fl5");
        apply(mk(4'b0000, 0,                    1, 1, 1, 0, 4'hF, 0, 0, 0,    all4,           4'b0000), "fl6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
